imm_encode_rv32i: RTL
=====================

// Module: imm_encode_rv32i
// PURPOSE
// - Instruction assembler: packs opcode, register fields, funct fields and a 32-bit
//   immediate into RV32I instruction words, i.e. the inverse of the immediate extender.
// - Feeds the boot/self-test instruction writer and the extender round-trip checker.
// - Registered valid/ready stream; the LI pseudo-op expands to LUI+ADDI (2 beats).
// PARAMETERS
// - RST_INSTR  32'h0000_0013  out_instr value after reset (NOP = ADDI x0,x0,0)
// - LI_SHORT   1              1: LI whose imm fits signed 12-bit emits one ADDI beat
// PORTS
// - clk        in   1   clock, all state on rising edge
// - rst        in   1   asynchronous, active-high reset
// - in_valid   in   1   request valid
// - in_ready   out  1   request accepted when in_valid && in_ready
// - in_fmt     in   3   000 I, 001 S, 010 B, 011 J, 100 U, 101 LI, 110 R, 111 illegal
// - in_opcode  in   7   opcode[6:0]; ignored for LI
// - in_rd      in   5   destination register
// - in_rs1     in   5   source register 1
// - in_rs2     in   5   source register 2
// - in_funct3  in   3   funct3; ignored for LI
// - in_funct7  in   7   funct7; R format only
// - in_imm     in   32  immediate, byte-offset form as produced by the extender
// - out_valid  out  1   out_instr valid
// - out_ready  in   1   consumer accepts when out_valid && out_ready
// - out_instr  out  32  encoded instruction word
// - out_last   out  1   final beat of the current request
// - out_err    out  1   request illegal/out of range (held with every beat of it)
// BEHAVIOUR
// - Reset: out_valid=0, out_last=0, out_err=0, out_instr=RST_INSTR, state EMPTY.
// - States: EMPTY (no beat held), LAST (final beat held), FIRST (LUI held, ADDI pending).
// - in_ready = (state==EMPTY) || (state==LAST && out_ready); combinational, no in_valid path.
// - Latency: accepted request appears on out_* the next cycle. Back-to-back one-beat
//   requests sustain 1 word/cycle.
// - EMPTY/LAST + accept: load word; go to FIRST for 2-beat LI, else LAST.
// - LAST + out_ready + no accept: go to EMPTY, out_valid=0.
// - FIRST + out_ready: load ADDI beat, go to LAST. in_ready=0 in FIRST.
// - Any state, out_valid && !out_ready: out_* held stable; no input accepted.
// - Encodings ({} MSB first):
//   I {imm[11:0],rs1,f3,rd,op}   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}   U {imm[31:12],rd,op}
//   R {f7,rs2,rs1,f3,rd,op}. Unused immediate bits are dropped.
// - LI: hi=(imm[31:12]+imm[11]) mod 2^20, lo=imm[11:0].
//   Beat 1 LUI {hi,rd,7'b0110111}. Beat 2 ADDI {lo,rd,3'b000,rd,7'b0010011}.
//   LI_SHORT=1 and imm in [-2048,2047]: one beat ADDI {lo,5'd0,3'b000,rd,7'b0010011}.
//   hi wraps: imm=32'h7FFF_F800 gives hi=20'h80000, lo=12'h800.
// - Illegal fmt 111: one beat, out_instr=32'hDEADBEEF, out_err=1, out_last=1.
// - out_last=1 only on the final beat; the LUI beat of a 2-beat LI has out_last=0.
// - Reset mid-LI (FIRST): pending ADDI dropped, EMPTY next, no partial beat after reset.
// CONFIGURATION
// - IMM_RANGE_CHECK_EN defined: out_err=1 (word still encoded, truncated) when
//   I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or imm[0]!=0;
//   J imm outside [-2^20,2^20-2] or imm[0]!=0; U imm[11:0]!=0.
//   R and LI never flag.
// - Not defined: no range logic; out_err=1 only for fmt 111; bits silently truncated.
// TESTING
// - I: fmt=000 op=0010011 rd=1 rs1=2 f3=0 imm=-1, out_ready=1 -> 32'hFFF1_0093, last=1, err=0.
// - B: fmt=010 op=1100011 rs1=1 rs2=2 f3=0 imm=-4 -> 32'hFE20_8EE3; feed into
//   extender imm_sel=010 -> 32'hFFFF_FFFC.
// - LI: imm=32'h1234_5FFF rd=5 -> LUI 32'h1234_62B7 (last=0), then ADDI
//   32'hFFF2_8293 (last=1); in_ready=0 between the two beats.
// - Stall: LI with out_ready=0 for 3 cycles -> LUI word stable, in_ready=0;
//   release -> ADDI next cycle; rst during FIRST -> out_valid=0, no ADDI later.
// - Throughput: 8 back-to-back I requests with out_ready=1 -> 8 words in 8
//   consecutive cycles, in order.
// - fmt=111 -> 32'hDEADBEEF, err=1. With IMM_RANGE_CHECK_EN: fmt=000 imm=2048 -> err=1;
//   fmt=011 imm=3 -> err=1. Without it: same requests -> err=0.

Source files
------------

// File: rtl/imm_encode_rv32i.sv
// ---------------------------------------------------------------------------
// ImmEncodeRv32i -- RV32I instruction assembler
//
// Packs opcode, register fields, funct fields and a 32-bit byte-offset
// immediate into RV32I instruction words. This is the inverse of the
// immediate extender. The LI pseudo-op expands to LUI followed by ADDI, or
// to a single ADDI when the immediate fits in signed 12 bits and LI_SHORT=1.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   -> out_err also flags immediates that do not fit the format
//                (the word is still emitted with the bits truncated)
//   undefined -> out_err is raised only for the illegal format 3'b111
//
// Parameters
//   RST_INSTR  out_instr value after reset (NOP = ADDI x0,x0,0)
//   LI_SHORT   1: an LI whose imm fits signed 12 bits emits a single ADDI
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake
//   in_fmt                 000 I, 001 S, 010 B, 011 J, 100 U, 101 LI, 110 R, 111 illegal
//   in_opcode, in_funct3   opcode and funct3 (ignored for LI)
//   in_funct7              funct7 (R format only)
//   in_rd, in_rs1, in_rs2  register fields
//   in_imm                 32-bit immediate
//   out_valid / out_ready  output beat handshake
//   out_instr              encoded instruction word
//   out_last               final beat of the current request
//   out_err                illegal request / immediate out of range
// ---------------------------------------------------------------------------
module imm_encode_rv32i #(
   parameter logic [31:0] RST_INSTR = 32'h0000_0013,
   parameter bit          LI_SHORT  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        out_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LAST  = 2'd1,
      FIRST = 2'd2
   } state_t;

   localparam logic [2:0] FMT_I  = 3'b000;
   localparam logic [2:0] FMT_S  = 3'b001;
   localparam logic [2:0] FMT_B  = 3'b010;
   localparam logic [2:0] FMT_J  = 3'b011;
   localparam logic [2:0] FMT_U  = 3'b100;
   localparam logic [2:0] FMT_LI = 3'b101;
   localparam logic [2:0] FMT_R  = 3'b110;

   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pend_q, pend_d;
   logic        last_q, last_d;
   logic        err_q, err_d;

   logic        accept;
   logic [31:0] encWord;
   logic [31:0] liAddi;
   logic [19:0] liHi;
   logic [11:0] liLo;
   logic        liFits;
   logic        encTwoBeat;
   logic        encErr;
   logic        rangeErr;

   // Handshake: a new request is taken when nothing is held, or when the
   // held final beat is leaving this cycle. The ADDI half of an LI blocks input.
   assign in_ready  = (state_q == EMPTY) || ((state_q == LAST) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q != EMPTY);
   assign out_instr = instr_q;
   assign out_last  = last_q;
   assign out_err   = err_q;

`ifdef IMM_RANGE_CHECK_EN
   // Immediate fit check: the upper bits must be a sign extension of the
   // field's top bit, and branch/jump offsets must be halfword aligned.
   always_comb begin
      rangeErr = 1'b0;
      case (in_fmt)
         FMT_I, FMT_S: rangeErr = (in_imm[31:11] != {21{in_imm[11]}});
         FMT_B:        rangeErr = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
         FMT_J:        rangeErr = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
         FMT_U:        rangeErr = (in_imm[11:0] != 12'd0);
         default:      rangeErr = 1'b0;
      endcase
   end
`else
   assign rangeErr = 1'b0;
`endif

   // Encoder for the first (or only) beat. For LI the upper part is rounded
   // up by imm[11] because ADDI sign-extends its 12-bit immediate.
   always_comb begin
      liLo       = in_imm[11:0];
      liHi       = in_imm[31:12] + {19'd0, in_imm[11]};
      liFits     = (in_imm[31:11] == {21{in_imm[11]}});
      liAddi     = {liLo, in_rd, 3'b000, in_rd, OP_ADDI};
      encWord    = 32'd0;
      encTwoBeat = 1'b0;
      encErr     = 1'b0;
      case (in_fmt)
         FMT_I: encWord = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S: encWord = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B: encWord = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
         FMT_J: encWord = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         FMT_U: encWord = {in_imm[31:12], in_rd, in_opcode};
         FMT_LI: begin
            if (LI_SHORT && liFits) begin
               encWord = {liLo, 5'd0, 3'b000, in_rd, OP_ADDI};
            end else begin
               encWord    = {liHi, in_rd, OP_LUI};
               encTwoBeat = 1'b1;
            end
         end
         FMT_R: encWord = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         default: begin
            encWord = 32'hDEAD_BEEF;
            encErr  = 1'b1;
         end
      endcase
      if (in_fmt != FMT_LI && in_fmt != FMT_R) begin
         encErr = encErr | rangeErr;
      end
   end

   // Output stage next-state. A held beat only changes when the consumer
   // takes it; the pending ADDI of a two-beat LI is parked in pend_q.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pend_d  = pend_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         EMPTY, LAST: begin
            if (accept) begin
               instr_d = encWord;
               pend_d  = liAddi;
               err_d   = encErr;
               last_d  = !encTwoBeat;
               state_d = encTwoBeat ? FIRST : LAST;
            end else if ((state_q == LAST) && out_ready) begin
               last_d  = 1'b0;
               err_d   = 1'b0;
               state_d = EMPTY;
            end
         end
         FIRST: begin
            if (out_ready) begin
               instr_d = pend_q;
               last_d  = 1'b1;
               err_d   = 1'b0;
               state_d = LAST;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State registers; reset drops any pending ADDI beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         instr_q <= RST_INSTR;
         pend_q  <= RST_INSTR;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule
